// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : aes_pkg
//  Description : Shared types and GF(2^8) helpers for the iterative AES
//                MixColumns engine. Multipliers reduce modulo
//                x^8 + x^4 + x^3 + x + 1 (0x11b).
//  Contents    : gf_xtime, gf_mul2/3/9/11/13/14, aes_col_t, aes_state_t,
//                mixcol_state_e
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } mixcol_state_e;

    localparam logic [7:0] C_GF_POLY = 8'h1b;

    // Multiply by x: shift left, fold the carried-out bit back with the
    // reduction polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? C_GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return gf_xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return gf_xtime(b) ^ b;
    endfunction

    // The inverse coefficients are built from the x^1, x^2, x^3 terms:
    // 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2.
    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_mixcol_word.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mixcol_word
//  Description : Combinational MixColumns transform of a single 32-bit
//                column. Byte 0 of the column is bits [31:24].
//  Ports       : col_i     - input column
//                inverse_i - 1 selects InvMixColumns
//                col_o     - transformed column
//  Build macro : AES_INV_MIXCOLUMNS_EN - when undefined the inverse
//                multipliers are not built and inverse_i is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_mixcol_word
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        inverse_i,
    output logic [31:0] col_o
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    aes_col_t   w_fwd;

    assign w_a0 = col_i[31:24];
    assign w_a1 = col_i[23:16];
    assign w_a2 = col_i[15:8];
    assign w_a3 = col_i[7:0];

    // Circulant {02,03,01,01}, each row rotated right by one byte position.
    assign w_fwd[31:24] = gf_mul2(w_a0) ^ gf_mul3(w_a1) ^ w_a2          ^ w_a3;
    assign w_fwd[23:16] = w_a0          ^ gf_mul2(w_a1) ^ gf_mul3(w_a2) ^ w_a3;
    assign w_fwd[15:8]  = w_a0          ^ w_a1          ^ gf_mul2(w_a2) ^ gf_mul3(w_a3);
    assign w_fwd[7:0]   = gf_mul3(w_a0) ^ w_a1          ^ w_a2          ^ gf_mul2(w_a3);

`ifdef AES_INV_MIXCOLUMNS_EN
    aes_col_t w_inv;

    // Circulant {0e,0b,0d,09}.
    assign w_inv[31:24] = gf_mul14(w_a0) ^ gf_mul11(w_a1) ^ gf_mul13(w_a2) ^ gf_mul9(w_a3);
    assign w_inv[23:16] = gf_mul9(w_a0)  ^ gf_mul14(w_a1) ^ gf_mul11(w_a2) ^ gf_mul13(w_a3);
    assign w_inv[15:8]  = gf_mul13(w_a0) ^ gf_mul9(w_a1)  ^ gf_mul14(w_a2) ^ gf_mul11(w_a3);
    assign w_inv[7:0]   = gf_mul11(w_a0) ^ gf_mul13(w_a1) ^ gf_mul9(w_a2)  ^ gf_mul14(w_a3);

    assign col_o = inverse_i ? w_inv : w_fwd;
`else
    logic w_unused_inverse;

    assign w_unused_inverse = inverse_i;
    assign col_o            = w_fwd;
`endif

endmodule : aes_mixcol_word
`default_nettype wire

// File: rtl/aes_mixcolumns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mixcolumns_iter
//  Description : Iterative, valid/ready handshaked AES MixColumns engine.
//                COLS_PER_CYCLE columns are transformed in place per clock;
//                a block takes NUM_PASSES = 4/COLS_PER_CYCLE MIX cycles.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid/in_ready   - input handshake
//                in_data, in_inverse - state and mode, sampled at accept
//                out_valid/out_ready - output handshake
//                out_data            - mixed state (column 0 = [127:96])
//                busy                - FSM not IDLE
//  Build macro : AES_INV_MIXCOLUMNS_EN - enables InvMixColumns via
//                in_inverse; otherwise every block uses the forward mix.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_mixcolumns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         NUM_PASSES = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] C_LAST_CNT = 2'(NUM_PASSES - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("aes_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mixcol_state_e fsm_q, fsm_d;
    aes_state_t    state_q, state_d;
    logic [1:0]    col_cnt_q, col_cnt_d;
    logic          w_inv;

    logic [1:0]    w_sel     [COLS_PER_CYCLE];
    aes_col_t      w_col_in  [COLS_PER_CYCLE];
    aes_col_t      w_col_out [COLS_PER_CYCLE];

    // Mode flag: registered at accept only when the inverse path exists.
`ifdef AES_INV_MIXCOLUMNS_EN
    logic inv_q, inv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign w_inv = inv_q;
`else
    logic w_unused_in_inverse;

    assign w_unused_in_inverse = in_inverse;
    assign w_inv               = 1'b0;
`endif

    // Column k of this pass is col_cnt*C + k. Column n lives at bit
    // offset (3-n)*32, and 3-n == ~n for a 2-bit index.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign w_sel[k]    = 2'((32'(col_cnt_q) * COLS_PER_CYCLE) + k);
        assign w_col_in[k] = state_q[{~w_sel[k], 5'b0} +: 32];

        aes_mixcol_word u_word (
            .col_i     (w_col_in[k]),
            .inverse_i (w_inv),
            .col_o     (w_col_out[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            col_cnt_q <= '0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    always_comb begin
        logic w_accept;

        fsm_d     = fsm_q;
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
`ifdef AES_INV_MIXCOLUMNS_EN
        inv_d     = inv_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_accept  = 1'b0;

        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                w_accept = in_valid;
            end

            MIX: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    state_d[{~w_sel[k], 5'b0} +: 32] = w_col_out[k];
                end
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == C_LAST_CNT) begin
                    fsm_d = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                // Ready passes through so a new block can be taken in the
                // same cycle the result is consumed.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_accept = 1'b1;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase

        if (w_accept) begin
            state_d   = in_data;
            col_cnt_d = 2'd0;
            fsm_d     = MIX;
`ifdef AES_INV_MIXCOLUMNS_EN
            inv_d     = in_inverse;
`endif
        end
    end

    assign out_data = state_q;

endmodule : aes_mixcolumns_iter
`default_nettype wire

// File: tb/tb_aes_mixcolumns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_mixcolumns_iter
//  Description : Directed self-checking bench for aes_mixcolumns_iter.
//                Three instances (COLS_PER_CYCLE = 1, 2, 4) share data,
//                mode, out_ready and reset; each has its own in_valid.
//  Build macro : AES_INV_MIXCOLUMNS_EN selects the inverse expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_mixcolumns_iter;

    localparam logic [127:0] C_V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] C_V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] C_V2_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] C_V2_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
`ifdef AES_INV_MIXCOLUMNS_EN
    localparam logic [127:0] C_V3_OUT = C_V1_IN;
`else
    // Forward mix of 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
    localparam logic [127:0] C_V3_OUT = 128'hcd504506_9f494f1f_01010101_c6c6c6c6;
`endif

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic         in_inverse;
    logic         out_ready;
    logic         in_valid_v  [3];
    logic         in_ready_v  [3];
    logic         out_valid_v [3];
    logic [127:0] out_data_v  [3];
    logic         busy_v      [3];

    int n_tests;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_data(in_data), .in_inverse(in_inverse), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .out_data(out_data_v[0]), .busy(busy_v[0])
    );

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_data(in_data), .in_inverse(in_inverse), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .out_data(out_data_v[1]), .busy(busy_v[1])
    );

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_data(in_data), .in_inverse(in_inverse), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .out_data(out_data_v[2]), .busy(busy_v[2])
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Accept one block on instance idx, wait (bounded) for out_valid,
    // check latency and data, then consume the result.
    task automatic run_block(input int idx, input logic [127:0] data, input logic inv,
                             input bit toggle, input logic [127:0] exp,
                             input int lat_exp, input string tag);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        in_data        = data;
        in_inverse     = inv;
        in_valid_v[idx] = 1'b1;
        @(negedge clk);
        in_valid_v[idx] = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (toggle) begin
                in_data    = {$urandom, $urandom, $urandom, $urandom};
                in_inverse = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (out_valid_v[idx]) begin
                seen = 1;
                lat  = k;
            end
        end
        check({tag, " latency"}, 128'(lat), 128'(lat_exp));
        check({tag, " data"}, out_data_v[idx], exp);
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
    endtask

    initial begin
        logic [127:0] snap;
        bit           stable;
        int           lat;

        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_data    = '0;
        in_inverse = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("reset in_ready",  128'(in_ready_v[0]),  128'd1);
        check("reset out_valid", 128'(out_valid_v[0]), 128'd0);
        check("reset out_data",  out_data_v[0],        128'd0);
        check("reset busy",      128'(busy_v[0]),      128'd0);
        rst_n = 1'b1;

        // FIPS-197 MixColumns example and round-1 vector on every width.
        run_block(0, C_V1_IN, 1'b0, 1'b0, C_V1_OUT, 4, "fwd1 c1");
        run_block(1, C_V1_IN, 1'b0, 1'b0, C_V1_OUT, 2, "fwd1 c2");
        run_block(2, C_V1_IN, 1'b0, 1'b0, C_V1_OUT, 1, "fwd1 c4");
        run_block(0, C_V2_IN, 1'b0, 1'b0, C_V2_OUT, 4, "fwd2 c1");
        run_block(1, C_V2_IN, 1'b0, 1'b0, C_V2_OUT, 2, "fwd2 c2");
        run_block(2, C_V2_IN, 1'b0, 1'b0, C_V2_OUT, 1, "fwd2 c4");

        // Inverse mode (or forward fallback when the inverse is not built).
        run_block(0, C_V1_OUT, 1'b1, 1'b0, C_V3_OUT, 4, "inv c1");
        run_block(2, C_V1_OUT, 1'b1, 1'b0, C_V3_OUT, 1, "inv c4");

        // Backpressure: result held in DONE, then back-to-back accept.
        @(negedge clk);
        in_data       = C_V1_IN;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("bp out_valid", 128'(out_valid_v[0]), 128'd1);
        snap   = out_data_v[0];
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (out_data_v[0] !== snap || out_valid_v[0] !== 1'b1) stable = 0;
        end
        check("bp stable",   128'(stable),         128'd1);
        check("bp in_ready", 128'(in_ready_v[0]),  128'd0);
        check("bp data",     snap,                 C_V1_OUT);
        out_ready     = 1'b1;
        in_valid_v[0] = 1'b1;
        in_data       = C_V2_IN;
        #1;
        check("bp ready pass", 128'(in_ready_v[0]), 128'd1);
        @(negedge clk);
        out_ready     = 1'b0;
        in_valid_v[0] = 1'b0;
        check("b2b busy",      128'(busy_v[0]),      128'd1);
        check("b2b out_valid", 128'(out_valid_v[0]), 128'd0);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid_v[0]) lat = k;
        end
        check("b2b latency", 128'(lat), 128'd4);
        check("b2b data",    out_data_v[0], C_V2_OUT);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second MIX cycle of the single-column instance.
        @(negedge clk);
        in_data       = C_V2_IN;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 128'(out_valid_v[0]), 128'd0);
        check("rst busy",      128'(busy_v[0]),      128'd0);
        check("rst out_data",  out_data_v[0],        128'd0);
        check("rst in_ready",  128'(in_ready_v[0]),  128'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_block(0, C_V1_IN, 1'b0, 1'b0, C_V1_OUT, 4, "post-rst c1");

        // Inputs toggling while busy must not disturb the captured block.
        run_block(0, C_V2_IN, 1'b0, 1'b1, C_V2_OUT, 4, "toggle c1");
        run_block(1, C_V2_IN, 1'b0, 1'b1, C_V2_OUT, 2, "toggle c2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_aes_mixcolumns_iter
`default_nettype wire
